// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the rv32 memory arbiter slice.
//   mem_src_e    - identifies which core port owns a memory transaction
//   MEM_BE_FULL  - byte enables used for instruction fetches (full word)
//   STARVE_CNT_W - width of the instruction starvation counter (limit <= 15)
package rv32_pkg;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mem_src_e;

  localparam logic [3:0]  MEM_BE_FULL  = 4'hF;
  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/rv32_arb_fifo.sv
// rv32_arb_fifo: small synchronous FIFO, used by the arbiter to remember the
// originator of every granted-but-unanswered memory transaction.
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   i_push, i_data    - write one entry (ignored when full)
//   i_pop             - drop the head entry (ignored when empty)
//   o_full, o_empty   - occupancy flags
//   o_head            - oldest entry
// Push and pop in the same cycle are both honoured; pointers wrap at DEPTH.
module rv32_arb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Pointer increment with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end else begin
        r_count <= r_count;
      end
    end
  end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one OBI-style memory port between the core's
// instruction-fetch and data ports.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   instr_req/addr, gnt/rvalid/rdata          - fetch interface
//   data_req/addr/wdata/we/be, gnt/rvalid/rdata - load/store interface
//   mem_req/addr/wdata/we/be, mem_gnt/rvalid/rdata - shared memory port
//   err_o                    - sticky: response seen with nothing outstanding
// Data wins ties unless the fetch side has watched STARVE_LIMIT data grants
// go by. A request left ungranted keeps its source for the next cycle so the
// memory payload stays stable. Responses are routed using an in-order FIFO of
// source ids.
module rv32_mem_arbiter
  import rv32_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  logic                    r_lock;
  mem_src_e                r_lock_src;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    r_err;

  mem_src_e w_sel_src;
  logic     w_sel_req;
  logic     w_full;
  logic     w_empty;
  logic     w_head;
  logic     w_grant;
  logic     w_fwd;
  logic     w_starved;

  assign w_starved = (r_starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  // Source selection: a locked source is kept, otherwise data priority with
  // the starvation override.
  always_comb begin
    w_sel_src = SRC_INSTR;
    w_sel_req = 1'b0;
    if (r_lock) begin
      w_sel_src = r_lock_src;
      w_sel_req = (r_lock_src == SRC_DATA) ? data_req_i : instr_req_i;
    end else if (data_req_i && instr_req_i) begin
      w_sel_src = w_starved ? SRC_INSTR : SRC_DATA;
      w_sel_req = 1'b1;
    end else if (data_req_i) begin
      w_sel_src = SRC_DATA;
      w_sel_req = 1'b1;
    end else if (instr_req_i) begin
      w_sel_src = SRC_INSTR;
      w_sel_req = 1'b1;
    end else begin
      w_sel_src = SRC_INSTR;
      w_sel_req = 1'b0;
    end
  end

  // The full flag is registered state, so a same-cycle response cannot
  // unblock a request combinationally.
  assign mem_req_o   = rst_ni & w_sel_req & ~w_full;
  assign w_grant     = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = w_grant & (w_sel_src == SRC_INSTR);
  assign data_gnt_o  = w_grant & (w_sel_src == SRC_DATA);

  // Payload mux; fetches are full-word reads. Held at zero during reset.
  always_comb begin
    mem_addr_o  = 32'h0000_0000;
    mem_wdata_o = 32'h0000_0000;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    if (!rst_ni) begin
      mem_be_o = 4'h0;
    end else if (w_sel_src == SRC_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
    end else begin
      mem_addr_o = instr_addr_i;
      mem_be_o   = MEM_BE_FULL;
    end
  end

  // Responses follow the head id; a response with nothing outstanding is
  // dropped here and flagged through r_err.
  assign w_fwd          = rst_ni & mem_rvalid_i & ~w_empty;
  assign instr_rvalid_o = w_fwd & (mem_src_e'(w_head) == SRC_INSTR);
  assign data_rvalid_o  = w_fwd & (mem_src_e'(w_head) == SRC_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign err_o          = r_err;

  // Outstanding-transaction source queue.
  rv32_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_src_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_grant),
    .i_data  (w_sel_src),
    .i_pop   (w_fwd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Lock, starvation counter and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock       <= 1'b0;
      r_lock_src   <= SRC_INSTR;
      r_starve_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      r_lock     <= mem_req_o & ~mem_gnt_i;
      r_lock_src <= w_sel_src;
      if (instr_gnt_o || !instr_req_i) begin
        r_starve_cnt <= '0;
      end else if (data_gnt_o && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
      if (mem_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Testbench for rv32_mem_arbiter: directed scenarios with literal expectations
// followed by randomized protocol-legal traffic, all checked every cycle
// against a queue-based behavioural model.
module tb_rv32_mem_arbiter;

  localparam int MAXO = 2;
  localparam int SLIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  rv32_mem_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (queue of owners) ----------------
  bit m_q[$];        // 0 = instruction, 1 = data, oldest first
  int m_lock = -1;   // source that must be kept, -1 when free
  int m_starve = 0;  // data grants seen while fetch waits
  bit m_err = 1'b0;
  int e_src;
  bit e_req, e_mreq, e_g, e_rv, e_head;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_gnts", {instr_gnt_o, data_gnt_o}, 0);
      chk("rst_rvalids", {instr_rvalid_o, data_rvalid_o}, 0);
      chk("rst_err", err_o, 0);
      chk("rst_payload", {mem_we_o, mem_be_o, mem_addr_o[26:0]}, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      m_q.delete();
      m_lock = -1;
      m_starve = 0;
      m_err = 1'b0;
    end else begin
      if (m_lock >= 0) begin
        e_src = m_lock;
        e_req = (m_lock == 1) ? data_req_i : instr_req_i;
      end else if (instr_req_i && data_req_i) begin
        e_src = (m_starve == SLIM) ? 0 : 1;
        e_req = 1'b1;
      end else begin
        e_src = data_req_i ? 1 : 0;
        e_req = data_req_i | instr_req_i;
      end
      e_mreq = e_req && (m_q.size() < MAXO);
      chk("mem_req", mem_req_o, e_mreq);
      if (e_mreq) begin
        chk("mem_addr", mem_addr_o, (e_src == 1) ? data_addr_i : instr_addr_i);
        chk("mem_wdata", mem_wdata_o, (e_src == 1) ? data_wdata_i : 32'd0);
        chk("mem_we", mem_we_o, (e_src == 1) ? data_we_i : 1'b0);
        chk("mem_be", mem_be_o, (e_src == 1) ? data_be_i : 4'hF);
      end
      e_g = e_mreq && mem_gnt_i;
      chk("instr_gnt", instr_gnt_o, e_g && (e_src == 0));
      chk("data_gnt", data_gnt_o, e_g && (e_src == 1));
      e_rv = mem_rvalid_i && (m_q.size() > 0);
      e_head = (m_q.size() > 0) ? m_q[0] : 1'b0;
      chk("instr_rvalid", instr_rvalid_o, e_rv && !e_head);
      chk("data_rvalid", data_rvalid_o, e_rv && e_head);
      if (mem_rvalid_i) begin
        chk("instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("data_rdata", data_rdata_o, mem_rdata_i);
      end
      chk("err", err_o, m_err);
      // state advance for the coming clock edge
      if (mem_rvalid_i && m_q.size() == 0) m_err = 1'b1;
      if (e_rv) void'(m_q.pop_front());
      if (e_g) m_q.push_back(e_src[0]);
      m_lock = (e_mreq && !mem_gnt_i) ? e_src : -1;
      if ((e_g && e_src == 0) || !instr_req_i) m_starve = 0;
      else if (e_g && e_src == 1 && m_starve < SLIM) m_starve++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(); @(posedge clk_i); #1; endtask
  task automatic smp(); @(negedge clk_i); #1; endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_addr_i = 0; data_wdata_i = 0; data_we_i = 0; data_be_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  bit [9:0] pat;
  bit gi, gd;
  int pend;

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    instr_req_i = 1; data_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    smp();
    chk("reset_outputs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o}, 0);
    idle_inputs();
    drv(); rst_ni = 1'b1;

    // single fetch and its response
    drv(); instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    smp(); chk("fetch_gnt", {instr_gnt_o, mem_req_o}, 2'b11); chk("fetch_addr", mem_addr_o, 32'h100);
    drv(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
    smp(); chk("fetch_rvalid", {instr_rvalid_o, data_rvalid_o}, 2'b10); chk("fetch_rdata", instr_rdata_o, 32'hDEADBEEF);

    // both requesting with the memory always granting: D,D,D,D,I repeating
    drv(); mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h104;
    data_req_i = 1; data_addr_i = 32'h3000; data_be_i = 4'hF; mem_gnt_i = 1;
    for (int i = 0; i < 10; i++) begin
      smp(); pat = {pat[8:0], data_gnt_o};
      drv(); mem_rvalid_i = 1; mem_rdata_i = $urandom;
    end
    instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
    smp(); chk("starve_pattern", pat, 10'b1111011110); chk("starve_last_rvalid", instr_rvalid_o, 1);

    // stalled store keeps its payload while fetch arrives
    drv(); mem_rvalid_i = 0; data_req_i = 1; data_addr_i = 32'h2000; data_wdata_i = 32'h1234_5678;
    data_we_i = 1; data_be_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("lock_payload", {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o}, 9'b1_1_0011_00);
      chk("lock_addr", mem_addr_o, 32'h2000);
      drv(); if (i == 0) begin instr_req_i = 1; instr_addr_i = 32'h300; end
    end
    mem_gnt_i = 1;
    smp(); chk("lock_data_gnt", data_gnt_o, 1); chk("lock_gnt_addr", mem_addr_o, 32'h2000);
    drv(); data_req_i = 0; data_we_i = 0;
    smp(); chk("after_lock_instr_gnt", instr_gnt_o, 1); chk("after_lock_addr", mem_addr_o, 32'h300);
    drv(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA0001;
    smp(); chk("order_first_data", {instr_rvalid_o, data_rvalid_o}, 2'b01);
    drv(); mem_rdata_i = 32'hAAAA0002;
    smp(); chk("order_second_instr", {instr_rvalid_o, data_rvalid_o}, 2'b10);

    // fill to MAX_OUTSTANDING, stall, then drain with same-cycle re-grant
    drv(); mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1;
    smp(); chk("full_i_gnt", instr_gnt_o, 1);
    drv(); instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h500; data_be_i = 4'hF;
    smp(); chk("full_d_gnt", data_gnt_o, 1);
    drv(); data_addr_i = 32'h504; instr_req_i = 1; instr_addr_i = 32'h600;
    smp(); chk("full_no_req", {mem_req_o, instr_gnt_o, data_gnt_o}, 0);
    drv();
    smp(); chk("full_no_req2", mem_req_o, 0);
    drv(); mem_rvalid_i = 1; mem_rdata_i = 32'hBBBB0001;
    smp(); chk("full_pop_instr", instr_rvalid_o, 1); chk("full_no_comb_req", mem_req_o, 0);
    drv(); mem_rdata_i = 32'hBBBB0002;
    smp(); chk("pop_data_and_regrant", {data_rvalid_o, mem_req_o, data_gnt_o}, 3'b111);
    chk("regrant_addr", mem_addr_o, 32'h504);
    drv(); mem_rvalid_i = 0; data_req_i = 0;
    smp(); chk("then_instr", instr_gnt_o, 1); chk("then_instr_addr", mem_addr_o, 32'h600);
    drv(); instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    smp(); chk("wrap_order_d", data_rvalid_o, 1);
    drv();
    smp(); chk("wrap_order_i", instr_rvalid_o, 1);

    // response with nothing outstanding
    drv(); mem_rvalid_i = 1;
    smp(); chk("spurious_no_fwd", {instr_rvalid_o, data_rvalid_o}, 0);
    drv(); mem_rvalid_i = 0;
    smp(); chk("err_set", err_o, 1);
    drv(); drv();
    smp(); chk("err_sticky", err_o, 1);

    // asynchronous reset in the middle of traffic
    drv(); instr_req_i = 1; instr_addr_i = 32'h700; data_req_i = 1; data_addr_i = 32'h800; mem_gnt_i = 1;
    smp();
    @(posedge clk_i); #3; rst_ni = 1'b0; #1;
    chk("async_rst_outputs", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, err_o, mem_we_o}, 0);
    chk("async_rst_payload", {mem_be_o, mem_addr_o[27:0]}, 0);
    idle_inputs();
    drv(); rst_ni = 1'b1;
    drv(); mem_rvalid_i = 1;
    smp(); chk("post_rst_resp_dropped", {instr_rvalid_o, data_rvalid_o}, 0);
    drv(); mem_rvalid_i = 0;
    smp(); chk("post_rst_err", err_o, 1);
    drv(); rst_ni = 1'b0;
    drv(); rst_ni = 1'b1;

    // randomized protocol-legal traffic
    gi = 0; gd = 0; pend = 0;
    for (int c = 0; c < 3000; c++) begin
      drv();
      if (!instr_req_i || gi) begin
        instr_req_i = ($urandom_range(0, 2) != 0);
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req_i || gd) begin
        data_req_i = ($urandom_range(0, 2) != 0);
        data_addr_i = $urandom;
        data_wdata_i = $urandom;
        data_we_i = $urandom_range(0, 1);
        data_be_i = 4'($urandom_range(1, 15));
      end
      mem_gnt_i = ((c % 500) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (pend > 0 && $urandom_range(0, 2) != 0) begin
        mem_rvalid_i = 1; pend--;
      end else begin
        mem_rvalid_i = 0;
      end
      mem_rdata_i = $urandom;
      @(negedge clk_i); #2;
      gi = instr_gnt_o; gd = data_gnt_o;
      if (mem_req_o && mem_gnt_i) pend++;
    end
    drv(); instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
    for (int c = 0; c < 20; c++) begin
      if (pend > 0) begin mem_rvalid_i = 1; pend--; end else mem_rvalid_i = 0;
      drv();
    end
    mem_rvalid_i = 0;
    smp(); chk("random_no_err", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
